// File: rtl/plab4_net_tdm_pkg.sv
// Shared constants and helpers for the TDM-protected ring router input controls.
package plab4_net_tdm_pkg;

  localparam int PORT_WEST = 0;
  localparam int PORT_TERM = 1;
  localparam int PORT_EAST = 2;

  // Ring injection needs two free slots so a flit can never take the last
  // buffer of the ring and deadlock it.
  localparam int BUBBLE_FREE_MIN = 2;

  // Width of an id field for n values, never narrower than one bit.
  function automatic int dom_nbits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/plab4_net_router_input_terminal_ctrl_tdm_if.sv
// Head-flit / arbiter handshake between the terminal input queue and the ring router.
interface plab4_net_router_input_terminal_ctrl_tdm_if
  import plab4_net_tdm_pkg::*;
#(
  parameter int p_num_routers    = 8,
  parameter int p_num_domains    = 2,
  parameter int p_num_free_nbits = 2
);

  localparam int RW = dom_nbits(p_num_routers);
  localparam int DW = dom_nbits(p_num_domains);

  logic [RW-1:0]               dest;
  logic [DW-1:0]               in_domain;
  logic                        in_val;
  logic                        in_rdy;
  logic [p_num_free_nbits-1:0] num_free_west;
  logic [p_num_free_nbits-1:0] num_free_east;
  logic [2:0]                  reqs;
  logic [2:0]                  grants;

  modport master (
    output dest, in_domain, in_val, num_free_west, num_free_east, grants,
    input  in_rdy, reqs
  );

  modport slave (
    input  dest, in_domain, in_val, num_free_west, num_free_east, grants,
    output in_rdy, reqs
  );

endinterface

// File: rtl/plab4_net_tdm_slot_sched.sv
// Static time-division scheduler: slot counter, owning-domain pointer and guard decode.
module plab4_net_tdm_slot_sched
  import plab4_net_tdm_pkg::*;
#(
  parameter int p_num_domains  = 2,
  parameter int p_slot_cycles  = 4,
  parameter int p_guard_cycles = 1
)(
  input  logic                                clk,
  input  logic                                reset,
  output logic [dom_nbits(p_num_domains)-1:0] cur_domain,
  output logic                                guard
);

  // One spare bit so the guard start can equal p_slot_cycles when there is no guard.
  localparam int CW = $clog2(p_slot_cycles) + 1;
  localparam int DW = dom_nbits(p_num_domains);

  localparam logic [CW-1:0] SLOT_LAST   = CW'(p_slot_cycles - 1);
  localparam logic [CW-1:0] GUARD_START = CW'(p_slot_cycles - p_guard_cycles);
  localparam logic [DW-1:0] DOM_LAST    = DW'(p_num_domains - 1);

  logic [CW-1:0] slot_cnt;
  logic [CW-1:0] slot_cnt_nxt;
  logic [DW-1:0] dom_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt   <= '0;
      cur_domain <= '0;
    end else begin
      slot_cnt   <= slot_cnt_nxt;
      cur_domain <= dom_nxt;
    end
  end

  // The schedule never skips idle domains, so slot timing leaks nothing about traffic.
  always_comb begin
    slot_cnt_nxt = slot_cnt + CW'(1);
    dom_nxt      = cur_domain;
    if (slot_cnt == SLOT_LAST) begin
      slot_cnt_nxt = '0;
      dom_nxt      = (cur_domain == DOM_LAST) ? '0 : cur_domain + DW'(1);
    end
  end

  assign guard = (slot_cnt >= GUARD_START);

endmodule

// File: rtl/plab4_net_router_input_terminal_ctrl_tdm.sv
// Terminal injection control: greedy ring routing, bubble flow control and
// per-domain TDM gating of head-flit requests.
module plab4_net_router_input_terminal_ctrl_tdm
  import plab4_net_tdm_pkg::*;
#(
  parameter int p_router_id      = 0,
  parameter int p_num_routers    = 8,
  parameter int p_num_free_nbits = 2,
  parameter int p_num_domains    = 2,
  parameter int p_slot_cycles    = 4,
  parameter int p_guard_cycles   = 1,
  parameter bit p_protect        = 1'b1
)(
  input  logic                                      clk,
  input  logic                                      reset,
  plab4_net_router_input_terminal_ctrl_tdm_if.slave bus,
  output logic [dom_nbits(p_num_domains)-1:0]       cur_domain,
  output logic                                      guard
);

  localparam int RW = dom_nbits(p_num_routers);

  // Hop arithmetic carries an extra bit so non-power-of-2 rings do not truncate.
  localparam logic [RW:0] N_EXT  = (RW+1)'(p_num_routers);
  localparam logic [RW:0] ID_EXT = (RW+1)'(p_router_id);

  plab4_net_tdm_slot_sched #(
    .p_num_domains  (p_num_domains),
    .p_slot_cycles  (p_slot_cycles),
    .p_guard_cycles (p_guard_cycles)
  ) u_sched (
    .clk        (clk),
    .reset      (reset),
    .cur_domain (cur_domain),
    .guard      (guard)
  );

  logic [RW:0] east_sum;
  logic [RW:0] east_hops;
  logic [RW:0] west_hops;
  logic [2:0]  route;

  always_comb begin
    east_sum  = {1'b0, bus.dest} + (N_EXT - ID_EXT);
    east_hops = (east_sum >= N_EXT) ? east_sum - N_EXT : east_sum;
    west_hops = N_EXT - east_hops;
    route     = '0;
    if (bus.dest == ID_EXT[RW-1:0])
      route[PORT_TERM] = 1'b1;
    else if (east_hops <= west_hops)
      route[PORT_EAST] = 1'b1;
    else
      route[PORT_WEST] = 1'b1;
  end

  logic dom_ok;
  logic elig;
  logic west_ok;
  logic east_ok;
  logic [2:0] reqs_c;

  // Reset gates requests directly because the domain match alone would pass at domain 0.
  assign dom_ok  = !p_protect || ((bus.in_domain == cur_domain) && !guard);
  assign elig    = reset && bus.in_val && dom_ok;
  assign west_ok = (32'(bus.num_free_west) >= BUBBLE_FREE_MIN);
  assign east_ok = (32'(bus.num_free_east) >= BUBBLE_FREE_MIN);

  always_comb begin
    reqs_c = '0;
    if (elig) begin
      if (route[PORT_TERM])
        reqs_c = route;
      else if (route[PORT_EAST] && east_ok)
        reqs_c = route;
      else if (route[PORT_WEST] && west_ok)
        reqs_c = route;
    end
  end

  assign bus.reqs   = reqs_c;
  assign bus.in_rdy = |(reqs_c & bus.grants);

endmodule

// File: tb/tb_plab4_net_router_input_terminal_ctrl_tdm.sv
// Directed-vector bench for the TDM terminal input control (router 2 of 8, 2 domains).
module tb_plab4_net_router_input_terminal_ctrl_tdm;

  logic clk;
  logic reset;
  logic       cur_domain, cur_domain_np;
  logic       guard, guard_np;

  int vectors;
  int miscompares;

  plab4_net_router_input_terminal_ctrl_tdm_if #(
    .p_num_routers(8), .p_num_domains(2), .p_num_free_nbits(2)
  ) bus ();

  plab4_net_router_input_terminal_ctrl_tdm_if #(
    .p_num_routers(8), .p_num_domains(2), .p_num_free_nbits(2)
  ) bus_np ();

  plab4_net_router_input_terminal_ctrl_tdm #(
    .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2),
    .p_num_domains(2), .p_slot_cycles(4), .p_guard_cycles(1), .p_protect(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .cur_domain(cur_domain), .guard(guard)
  );

  plab4_net_router_input_terminal_ctrl_tdm #(
    .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2),
    .p_num_domains(2), .p_slot_cycles(4), .p_guard_cycles(1), .p_protect(1'b0)
  ) dut_np (
    .clk(clk), .reset(reset), .bus(bus_np), .cur_domain(cur_domain_np), .guard(guard_np)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] dom_seq;
  logic [15:0] guard_seq;

  initial begin
    vectors     = 0;
    miscompares = 0;
    dom_seq     = 16'hF0F0;
    guard_seq   = 16'h8888;

    reset              = 1'b0;
    bus.in_val         = 1'b1;
    bus.in_domain      = 1'b0;
    bus.dest           = 3'd3;
    bus.num_free_west  = 2'd3;
    bus.num_free_east  = 2'd3;
    bus.grants         = 3'b111;
    bus_np.in_val        = 1'b1;
    bus_np.in_domain     = 1'b1;
    bus_np.dest          = 3'd3;
    bus_np.num_free_west = 2'd3;
    bus_np.num_free_east = 2'd3;
    bus_np.grants        = 3'b111;

    tick();
    tick();
    chk("rst_slot_cnt", 32'(dut.u_sched.slot_cnt), 32'd0);
    chk("rst_cur_domain", 32'(cur_domain), 32'd0);
    chk("rst_guard", 32'(guard), 32'd0);
    chk("rst_reqs", 32'(bus.reqs), 32'd0);
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
    chk("rst_np_reqs", 32'(bus_np.reqs), 32'd0);

    @(negedge clk);
    bus.in_val    = 1'b0;
    bus_np.in_val = 1'b0;
    reset         = 1'b1;
    #1;

    // position 0 .. 15 of the schedule
    for (int i = 0; i < 16; i++) begin
      chk("sched_domain", 32'(cur_domain), 32'(dom_seq[i]));
      chk("sched_guard", 32'(guard), 32'(guard_seq[i]));
      tick();
    end

    // position 16: domain 0, slot_cnt 0
    bus.in_val        = 1'b1;
    bus.in_domain     = 1'b0;
    bus.dest          = 3'd3;
    bus.num_free_east = 2'd2;
    bus.num_free_west = 2'd0;
    bus.grants        = 3'b100;
    #1;
    chk("d0_inslot_reqs", 32'(bus.reqs), 32'h4);
    chk("d0_inslot_rdy", 32'(bus.in_rdy), 32'd1);

    repeat (4) tick();
    // position 20: domain 1 slot
    chk("d0_offslot_reqs", 32'(bus.reqs), 32'h0);
    chk("d0_offslot_rdy", 32'(bus.in_rdy), 32'd0);

    repeat (3) tick();
    // position 23: domain 1, guard cycle
    bus.in_domain     = 1'b1;
    bus.dest          = 3'd7;
    bus.num_free_west = 2'd2;
    bus.grants        = 3'b001;
    #1;
    chk("d1_guard_flag", 32'(guard), 32'd1);
    chk("d1_guard_reqs", 32'(bus.reqs), 32'h0);
    chk("d1_guard_rdy", 32'(bus.in_rdy), 32'd0);

    repeat (5) tick();
    // position 28: next domain-1 slot, slot_cnt 0
    chk("d1_next_domain", 32'(cur_domain), 32'd1);
    chk("d1_next_reqs", 32'(bus.reqs), 32'h1);
    chk("d1_next_rdy", 32'(bus.in_rdy), 32'd1);

    repeat (4) tick();
    // position 32: domain 0, slot_cnt 0
    bus.in_domain     = 1'b0;
    bus.dest          = 3'd1;
    bus.num_free_west = 2'd1;
    bus.grants        = 3'b000;
    #1;
    chk("bubble_w1_reqs", 32'(bus.reqs), 32'h0);
    bus.num_free_west = 2'd2;
    #1;
    chk("bubble_w2_reqs", 32'(bus.reqs), 32'h1);
    chk("bubble_nogrant_rdy", 32'(bus.in_rdy), 32'd0);
    bus.grants = 3'b001;
    #1;
    chk("bubble_grant_rdy", 32'(bus.in_rdy), 32'd1);

    bus.num_free_west = 2'd0;
    bus.num_free_east = 2'd0;
    bus.dest          = 3'd2;
    bus.grants        = 3'b010;
    #1;
    chk("route_term_reqs", 32'(bus.reqs), 32'h2);
    chk("route_term_rdy", 32'(bus.in_rdy), 32'd1);
    bus.dest = 3'd6;
    #1;
    chk("route_tie_nocredit", 32'(bus.reqs), 32'h0);
    bus.num_free_east = 2'd2;
    #1;
    chk("route_tie_east", 32'(bus.reqs), 32'h4);
    bus.dest   = 3'd5;
    bus.grants = 3'b0xx;
    #1;
    chk("route_d5_east", 32'(bus.reqs), 32'h4);
    chk("xgrant_ignored_rdy", 32'(bus.in_rdy), 32'd0);
    bus.dest          = 3'd0;
    bus.num_free_west = 2'd2;
    bus.grants        = 3'b000;
    #1;
    chk("route_d0_west", 32'(bus.reqs), 32'h1);

    repeat (3) tick();
    // position 35: domain 0 guard cycle
    bus.in_domain        = 1'b1;
    bus.dest             = 3'd3;
    bus.grants           = 3'b100;
    bus_np.in_val        = 1'b1;
    bus_np.in_domain     = 1'b1;
    bus_np.dest          = 3'd3;
    bus_np.num_free_east = 2'd2;
    bus_np.num_free_west = 2'd0;
    bus_np.grants        = 3'b100;
    #1;
    chk("np_guard_reqs", 32'(bus_np.reqs), 32'h4);
    chk("np_guard_rdy", 32'(bus_np.in_rdy), 32'd1);
    chk("prot_guard_reqs", 32'(bus.reqs), 32'h0);

    repeat (2) tick();
    // position 37: domain 1, slot_cnt 1
    chk("pre_rst_domain", 32'(cur_domain), 32'd1);
    chk("pre_rst_slot_cnt", 32'(dut.u_sched.slot_cnt), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_np_reqs", 32'(bus_np.reqs), 32'h0);
    chk("midrst_np_rdy", 32'(bus_np.in_rdy), 32'd0);
    chk("midrst_domain", 32'(cur_domain), 32'd0);
    chk("midrst_slot_cnt", 32'(dut.u_sched.slot_cnt), 32'd0);
    tick();
    chk("midrst_hold_reqs", 32'(bus_np.reqs), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_domain", 32'(cur_domain_np), 32'd0);
    chk("rel_slot_cnt", 32'(dut_np.u_sched.slot_cnt), 32'd0);
    chk("rel_np_reqs", 32'(bus_np.reqs), 32'h4);
    tick();
    chk("rel_slot_cnt_1", 32'(dut.u_sched.slot_cnt), 32'd1);
    chk("rel_domain_1", 32'(cur_domain), 32'd0);
    repeat (3) tick();
    chk("rel_domain_next", 32'(cur_domain), 32'd1);
    chk("rel_guard_off", 32'(guard), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/plab4_net_router_input_terminal_ctrl_tdm.md
Name: plab4_net_router_input_terminal_ctrl_tdm

Overview:
Injection-side (terminal input) control for one ring router, with timing-channel protection generalised from two hard-wired domain strobes to N security domains. An internal time-division scheduler owns the active-domain sequence. A head flit may request an output only during its own domain's slot, and never during the slot's trailing guard window. Routing is greedy (shortest direction) with bubble flow control on ring injection; the block sits between the terminal input queue and the router's output arbiters.

Parameters:
p_router_id, 0, this router's index on the ring
p_num_routers, 8, ring size; router ids are 0..p_num_routers-1
p_num_free_nbits, 2, width of the downstream free-slot counts
p_num_domains, 2, number of security domains, >=1
p_slot_cycles, 4, cycles per domain slot, >=2
p_guard_cycles, 1, trailing cycles of each slot with injection suppressed; 0 <= value < p_slot_cycles
p_protect, 1, 1 = TDM protection on; 0 = any domain may request every cycle (scheduler still runs)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset (0 = in reset)
dest  in  clog2(p_num_routers)  destination id of the head flit
in_domain  in  clog2(p_num_domains) (min 1)  security-domain tag of the head flit
in_val  in  1  head flit valid
in_rdy  out  1  head flit accepted this cycle
num_free_west  in  p_num_free_nbits  free entries in the west output queue
num_free_east  in  p_num_free_nbits  free entries in the east output queue
reqs  out  3  requests: [0] west, [1] terminal, [2] east
grants  in  3  one-hot grants from the output arbiters
cur_domain  out  clog2(p_num_domains) (min 1)  domain owning the current slot
guard  out  1  current cycle is in the guard window

Behaviour:
- Reset is asynchronous, active-low. While asserted: slot_cnt=0, cur_domain=0, guard=0, reqs=000, in_rdy=0 regardless of inputs.
- Scheduler:
  - slot_cnt counts 0..p_slot_cycles-1 and increments each cycle.
  - On wrap, cur_domain advances; it wraps from p_num_domains-1 to 0.
  - The schedule is static and never skips idle domains, so slot timing is independent of traffic.
  - guard = (slot_cnt >= p_slot_cycles-p_guard_cycles). It is combinational from registered state.
  - With p_num_domains=1, cur_domain stays 0 and guard still applies.
- Route (combinational):
  - dest == p_router_id -> terminal.
  - Otherwise east_hops = (dest - p_router_id) mod p_num_routers, west_hops = p_num_routers - east_hops.
  - Pick east if east_hops <= west_hops (tie -> east), else west.
  - Modular arithmetic uses one extra bit so there is no truncation for non-power-of-2 rings.
- Eligibility:
  - elig = in_val & (p_protect==0 | (in_domain==cur_domain & ~guard)).
  - Bubble rule: an east/west request additionally requires that port's num_free >= 2. Terminal ejection has no credit requirement.
  - reqs = route one-hot when eligible, else 000.
  - An ineligible flit waits; it is never dropped or re-routed.
- Handshake: in_rdy = |(reqs & grants). Grant bits on non-requested ports are ignored, including X.
- All outputs are combinational from inputs and registered state; acceptance has zero added latency.
- No grant hold: packets are single-flit.
- Guard window: ensures a flit injected in a slot clears the injection port before the next domain's slot begins.
- Reset asserted mid-slot: the schedule restarts at domain 0, slot_cnt 0 on the first cycle after deassertion.
- in_domain >= p_num_domains never matches and is never eligible when p_protect=1.

Decomposition:
- Shared package plab4_net_tdm_pkg holds:
  - port-index constants PORT_WEST=0, PORT_TERM=1, PORT_EAST=2;
  - the bubble threshold constant (2);
  - a function computing domain-id width.
- Sub-module plab4_net_tdm_slot_sched contains the slot counter, domain pointer and guard decode. It is reused by the other TDM-protected input controls.

Test Plan:
- Reset, then free-run 16 cycles with id=2, 8 routers, 2 domains, slot=4, guard=1 -> cur_domain sequence 0,0,0,0,1,1,1,1,0...; guard=1 at slot_cnt 3 only.
- Domain 0 flit, dest=3, free_e=2, grants=100 at slot_cnt 0 -> reqs=100, in_rdy=1. Same flit while cur_domain=1 -> reqs=000, in_rdy=0.
- Domain 1 flit, dest=7, in slot 1 at slot_cnt 3 (guard) -> reqs=000. Same flit at next domain-1 slot_cnt 0 with free_w=2 -> reqs=001.
- Bubble: dest=1, domain 0 in-slot, free_w=1 -> reqs=000. Raise free_w to 2 -> reqs=001; grants=001 -> in_rdy=1.
- Routing: dest=2 -> 010 (no credit needed, free_e=free_w=0); dest=6 (tie) -> 100; dest=5 -> 100; dest=0 -> 001.
- p_protect=0: domain-1 flit, dest=3, during domain-0 guard cycle -> reqs=100. Assert reset mid-slot with in_val=1 -> reqs=000, in_rdy=0; after release cur_domain=0, slot_cnt=0.
